// File: rtl/srt_div_issue_ctrl_if.sv
// Handshake bundle between the SRT divide issue controller, its requester,
// the divider datapath and the result consumer.
interface srt_div_issue_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TAG_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_dividend;
    logic [DATA_WIDTH-1:0] in_divisor;
    logic [TAG_WIDTH-1:0]  in_tag;

    logic                  div_enable;
    logic [DATA_WIDTH-1:0] div_dividend;
    logic [DATA_WIDTH-1:0] div_divisor;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_quotient;
    logic [DATA_WIDTH-1:0] out_remainder;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_dz;

    logic                  busy;

    // Controller side
    modport slave (
        input  in_valid, in_dividend, in_divisor, in_tag,
        input  div_quotient, div_remainder,
        input  out_ready,
        output in_ready,
        output div_enable, div_dividend, div_divisor,
        output out_valid, out_quotient, out_remainder, out_tag, out_dz,
        output busy
    );

    // Requester / divider / consumer side
    modport master (
        output in_valid, in_dividend, in_divisor, in_tag,
        output div_quotient, div_remainder,
        output out_ready,
        input  in_ready,
        input  div_enable, div_dividend, div_divisor,
        input  out_valid, out_quotient, out_remainder, out_tag, out_dz,
        input  busy
    );
endinterface

// File: rtl/srt_div_issue_ctrl.sv
// Operand-issue and result-capture sequencer for the radix-4 SRT divider.
// Divide-by-zero is answered locally without issuing to the divider.
module srt_div_issue_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned Q_SAMPLE   = 6,
    parameter int unsigned R_SAMPLE   = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    srt_div_issue_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(R_SAMPLE + 1);
    localparam logic [CW-1:0] Q_K = CW'(Q_SAMPLE);
    localparam logic [CW-1:0] R_K = CW'(R_SAMPLE);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  dz_q, dz_d;

    logic                  in_ready_c;
    logic                  div_enable_c;
    logic                  out_valid_c;
    logic                  busy_c;
    logic [CW-1:0]         k;
    logic                  divisor_zero;

    // k is the number of cycles elapsed since the ISSUE cycle while in WAIT
    assign k            = cnt_q + CW'(1);
    assign divisor_zero = (bus.in_divisor == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.in_valid) state_d = divisor_zero ? HOLD : ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (k == R_K) state_d = HOLD;
            HOLD:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c   = 1'b0;
        div_enable_c = 1'b0;
        out_valid_c  = 1'b0;
        busy_c       = (state_q != IDLE);
        cnt_d        = cnt_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        tag_d        = tag_q;
        dz_d         = dz_q;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    dvd_d = bus.in_dividend;
                    dvs_d = bus.in_divisor;
                    tag_d = bus.in_tag;
                    if (divisor_zero) begin
                        quo_d = '1;
                        rem_d = bus.in_dividend;
                        dz_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                div_enable_c = 1'b1;
                cnt_d        = '0;
            end
            WAIT: begin
                cnt_d = k;
                // Independent ifs so Q_SAMPLE == R_SAMPLE captures both together
                if (k == Q_K) quo_d = bus.div_quotient;
                if (k == R_K) begin
                    rem_d = bus.div_remainder;
                    dz_d  = 1'b0;
                end
            end
            HOLD: out_valid_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.div_enable    = div_enable_c;
    assign bus.div_dividend  = dvd_q;
    assign bus.div_divisor   = dvs_q;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_quotient  = quo_q;
    assign bus.out_remainder = rem_q;
    assign bus.out_tag       = tag_q;
    assign bus.out_dz        = dz_q;
    assign bus.busy          = busy_c;
endmodule

// File: tb/tb_srt_div_issue_ctrl.sv
// Randomized bench for srt_div_issue_ctrl with a cycle-tagged divider model
// and an arithmetic reference for quotient, remainder and latency.
module tb_srt_div_issue_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 4;
    localparam int unsigned QS = 6;
    localparam int unsigned RS = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    srt_div_issue_ctrl_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    srt_div_issue_ctrl #(
        .DATA_WIDTH(DW),
        .TAG_WIDTH (TW),
        .Q_SAMPLE  (QS),
        .R_SAMPLE  (RS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Divider model: the true result is visible only at its own k, every other
    // cycle shows a distinct wrong value, so a misplaced sample is caught.
    int unsigned   kk = 0;
    logic [DW-1:0] mq = '0;
    logic [DW-1:0] mr = '0;
    always @(posedge clk) begin
        if (!reset_n) begin
            kk <= 0;
        end else if (bus.div_enable) begin
            kk <= 1;
            if (bus.div_divisor == '0) begin
                mq <= '1;
                mr <= bus.div_dividend;
            end else begin
                mq <= bus.div_dividend / bus.div_divisor;
                mr <= bus.div_dividend % bus.div_divisor;
            end
        end else if (kk != 0 && kk < 30) begin
            kk <= kk + 1;
        end
    end
    assign bus.div_quotient  = (kk == QS) ? mq : (mq ^ DW'(kk | 32'h80));
    assign bus.div_remainder = (kk == RS) ? mr : (mr ^ DW'(kk | 32'h40));

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned en_count = 0;
    int unsigned en_consec = 0;
    int unsigned last_en_cyc = 0;
    int unsigned en_gap = 0;
    logic        prev_en = 1'b0;
    always @(negedge clk) begin
        if (bus.div_enable) begin
            en_count++;
            if (prev_en) en_consec++;
            en_gap      = cyc - last_en_cyc;
            last_en_cyc = cyc;
        end
        prev_en = bus.div_enable;
    end

    // One request end to end; stall = cycles out_ready is held low in HOLD.
    task automatic run_req(input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                           input logic [TW-1:0] tag, input int unsigned stall);
        int unsigned   wait_n;
        int unsigned   lat;
        int unsigned   en0;
        logic [DW-1:0] eq, er;
        wait_n = 0;
        while (!bus.in_ready && wait_n < 50) begin
            step();
            wait_n++;
        end
        chk("in_ready_idle", bus.in_ready, 1);
        eq = (dvs == 0) ? '1  : dvd / dvs;
        er = (dvs == 0) ? dvd : dvd % dvs;
        en0 = en_count;
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_dividend = dvd;
        bus.in_divisor  = dvs;
        bus.in_tag      = tag;
        step();
        bus.in_valid    = 1'b0;
        bus.in_dividend = DW'($urandom);
        bus.in_divisor  = DW'($urandom);
        bus.in_tag      = TW'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("latency", lat, (dvs == 0) ? 1 : RS + 2);
        chk("quotient", bus.out_quotient, eq);
        chk("remainder", bus.out_remainder, er);
        chk("tag", bus.out_tag, tag);
        chk("dz", bus.out_dz, (dvs == 0));
        chk("busy_hold", bus.busy, 1);
        for (int i = 0; i < int'(stall); i++) begin
            bus.in_valid    = 1'b1;
            bus.in_dividend = DW'($urandom);
            bus.in_divisor  = DW'($urandom);
            bus.in_tag      = TW'($urandom);
            step();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_quotient", bus.out_quotient, eq);
            chk("hold_remainder", bus.out_remainder, er);
            chk("hold_tag", bus.out_tag, tag);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("valid_drop", bus.out_valid, 0);
        chk("in_ready_back", bus.in_ready, 1);
        chk("busy_idle", bus.busy, 0);
        chk("enable_pulses", en_count - en0, (dvs != 0) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned   lat;
        int unsigned   wait_n;
        logic [DW-1:0] dvd, dvs;
        logic [TW-1:0] tag;

        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b0;
        reset_n         = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_div_enable", bus.div_enable, 0);
        chk("rst_quotient", bus.out_quotient, 0);
        chk("rst_div_divisor", bus.div_divisor, 0);
        reset_n = 1'b1;
        step();

        // Reset while waiting at k=3
        bus.in_valid    = 1'b1;
        bus.in_dividend = 8'd100;
        bus.in_divisor  = 8'd7;
        bus.in_tag      = 4'd9;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_div_enable", bus.div_enable, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_div_dividend", bus.div_dividend, 0);
        run_req(8'd100, 8'd7, 4'd3, 0);

        run_req(8'd200, 8'd7, 4'd5, 0);
        run_req(8'd57, 8'd0, 4'd2, 0);
        run_req(8'd255, 8'd1, 4'd11, 20);
        run_req(8'd0, 8'd255, 4'd0, 1);

        // Back-to-back with out_ready tied high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dvd = DW'($urandom);
            dvs = DW'($urandom_range(1, 255));
            tag = TW'(i);
            wait_n = 0;
            while (!bus.in_ready && wait_n < 50) begin
                step();
                wait_n++;
            end
            chk("b2b_in_ready", bus.in_ready, 1);
            bus.in_valid    = 1'b1;
            bus.in_dividend = dvd;
            bus.in_divisor  = dvs;
            bus.in_tag      = tag;
            step();
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < 40) begin
                step();
                lat++;
            end
            chk("b2b_latency", lat, RS + 2);
            chk("b2b_quotient", bus.out_quotient, dvd / dvs);
            chk("b2b_remainder", bus.out_remainder, dvd % dvs);
            chk("b2b_tag", bus.out_tag, tag);
            if (i > 0) chk("b2b_issue_gap", en_gap, RS + 3);
            step();
        end
        bus.out_ready = 1'b0;

        // Mixed random traffic with occasional zero divisors and stalls
        for (int i = 0; i < 20; i++) begin
            dvd = DW'($urandom);
            dvs = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
            run_req(dvd, dvs, TW'($urandom), $urandom_range(0, 3));
        end

        chk("enable_consecutive", en_consec, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/srt_div_issue_ctrl.md
# srt_div_issue_ctrl

Operand-issue and result-capture sequencer for the radix-4 SRT divider. Accepts divide requests on a valid/ready input channel, issues each to the divider with a one-cycle enable pulse, samples quotient and remainder at fixed cycle offsets, and holds the result on a valid/ready output channel until it is consumed. Divide-by-zero is resolved locally and never issued to the divider.

## Interface
- DATA_WIDTH, 8: operand/result width; must match the divider.
- TAG_WIDTH, 4: opaque request tag carried to the result.
- Q_SAMPLE, 6: cycles after the issue cycle at which div_quotient is sampled.
- R_SAMPLE, 7: cycles after the issue cycle at which div_remainder is sampled; requires R_SAMPLE >= Q_SAMPLE >= 1.
- clk  input  1  clock; all logic on the rising edge.
- reset_n  input  1  one clock; reset is synchronous and active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- in_dividend  input  DATA_WIDTH  unsigned dividend.
- in_divisor  input  DATA_WIDTH  unsigned divisor.
- in_tag  input  TAG_WIDTH  request tag.
- div_enable  output  1  one-cycle issue pulse to the divider.
- div_dividend, div_divisor  output  DATA_WIDTH each  registered operands; stable from accept until the next accept.
- div_quotient  input  DATA_WIDTH  divider quotient.
- div_remainder  input  DATA_WIDTH  divider remainder.
- out_valid  output  1  result valid.
- out_ready  input  1  result accepted.
- out_quotient, out_remainder  output  DATA_WIDTH each.
- out_tag  output  TAG_WIDTH.
- out_dz  output  1  divide-by-zero flag for this result.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD. All registered outputs reset to 0; the state resets to IDLE.
- IDLE: in_ready=1. On in_valid, latch the dividend, divisor and tag.
  - Divisor nonzero: go to ISSUE.
  - Divisor zero: go directly to HOLD with out_quotient = all ones, out_remainder = dividend, out_dz = 1.
- ISSUE: lasts exactly one cycle.
  - div_enable=1 and the counter clears to 0.
  - Go to WAIT.
- WAIT: the counter increments each cycle, reaching k on the k-th cycle after ISSUE.
  - When k == Q_SAMPLE, capture div_quotient.
  - When k == R_SAMPLE, capture div_remainder, set out_dz = 0, and go to HOLD.
  - If Q_SAMPLE == R_SAMPLE, both captures happen in the same cycle.
- HOLD: out_valid=1. out_quotient, out_remainder, out_tag and out_dz stay stable.
  - On out_ready, go to IDLE.
  - out_valid drops in the following cycle.
- div_enable is never high outside ISSUE, and never high for two consecutive cycles.
- The counter width is $clog2(R_SAMPLE+1); the counter never wraps.
- Inputs are ignored when in_ready=0; requests are not queued.
- A reset_n=0 sample at any edge, in any state, forces IDLE and clears all registered outputs. A result that is pending or in flight is discarded. The divider is reset from the same reset_n.

## Timing
- Accept edge at cycle A, nonzero divisor:
  - div_enable is high in cycle A+1.
  - Quotient is sampled at A+1+Q_SAMPLE.
  - out_valid first goes high in cycle A+2+R_SAMPLE (A+9 with defaults).
- Zero divisor: out_valid is high in cycle A+1.
- Minimum issue-to-issue spacing with out_ready tied high: R_SAMPLE+3 cycles (10 with defaults).
- in_ready returns to 1 in the cycle after the out_valid&&out_ready edge.
- No combinational path from any input to any output except in_ready, which depends on state only.

## Test plan
- Reset mid-WAIT:
  - Stimulus: pull reset_n low for one edge at k=3.
  - Required: next cycle is IDLE with out_valid=0, div_enable=0, busy=0; a fresh 100/7 then completes normally.
- Basic divide, out_ready held high:
  - Stimulus: dividend 200, divisor 7, tag 5, with a model divider of the default latency.
  - Required: out_quotient=28, out_remainder=4, out_tag=5, out_dz=0; out_valid appears 9 cycles after accept; div_enable pulses exactly once.
- Divide by zero:
  - Stimulus: dividend 57, divisor 0.
  - Required: out_valid in the next cycle; quotient 0xFF, remainder 57, out_dz=1; div_enable is never asserted.
- Backpressure:
  - Stimulus: 255/1 with out_ready low for 20 cycles.
  - Required: outputs hold quotient 255 and remainder 0 throughout; in_ready=0; a second in_valid during the hold is not accepted. Then out_ready high for one cycle: accept occurs, in_ready=1 the next cycle.
- Back-to-back:
  - Stimulus: 16 random requests, out_ready tied high.
  - Required: results match the reference model in order with matching tags; issue spacing is exactly 10 cycles.
- Sampling offsets:
  - Stimulus: divider model drives distinct values on div_quotient/div_remainder at each k.
  - Required: captured quotient equals the value at k=6 and captured remainder the value at k=7.
